// File: rtl/ddr3_fifo_scheduler.sv
// Arbitrates the cache write-back and read-request FIFOs onto a single DDR3 controller
// command port and returns read fill data to the read-out FIFO. One transaction in flight.
module ddr3_fifo_scheduler #(
    parameter int unsigned WR_STARVE_MAX = 8,
    parameter int unsigned RD_TIMEOUT    = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wf_empty,
    input  logic [31:0]  wf_addr,
    input  logic [127:0] wf_data,
    output logic         wf_pop,
    input  logic         rf_empty,
    input  logic [31:0]  rf_addr,
    output logic         rf_pop,
    input  logic         of_full,
    output logic         of_push,
    output logic [127:0] of_data,
    output logic         mc_cmd_valid,
    input  logic         mc_cmd_ready,
    output logic         mc_cmd_write,
    output logic [31:0]  mc_cmd_addr,
    output logic [127:0] mc_wdata,
    input  logic         mc_rdata_valid,
    input  logic [127:0] mc_rdata,
    output logic         busy,
    output logic         rd_timeout
);

    localparam int unsigned SW = $clog2(WR_STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_WAIT,
        RD_PUSH
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   timer;
    logic            hazard;
    logic            rd_ok;
    logic            grant_wr;
    logic            grant_rd;
    logic            unused_addr_bits;

    // Line offsets never reach the controller; only [31:4] matters.
    assign unused_addr_bits = ^{wf_addr[3:0], rf_addr[3:0]};

    always_comb begin
        hazard   = 1'b0;
        rd_ok    = 1'b0;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        hazard   = !wf_empty && !rf_empty && (wf_addr[31:4] == rf_addr[31:4]);
        rd_ok    = !rf_empty && (wf_empty || (starve_cnt < SW'(WR_STARVE_MAX)));
        grant_wr = hazard || (!rd_ok && !wf_empty);
        grant_rd = !hazard && rd_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            timer        <= '0;
            wf_pop       <= 1'b0;
            rf_pop       <= 1'b0;
            of_push      <= 1'b0;
            of_data      <= '0;
            mc_cmd_valid <= 1'b0;
            mc_cmd_write <= 1'b0;
            mc_cmd_addr  <= '0;
            mc_wdata     <= '0;
            busy         <= 1'b0;
            rd_timeout   <= 1'b0;
        end else begin
            wf_pop  <= 1'b0;
            rf_pop  <= 1'b0;
            of_push <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state        <= WR_CMD;
                        busy         <= 1'b1;
                        wf_pop       <= 1'b1;
                        mc_cmd_valid <= 1'b1;
                        mc_cmd_write <= 1'b1;
                        mc_cmd_addr  <= {wf_addr[31:4], 4'h0};
                        mc_wdata     <= wf_data;
                        starve_cnt   <= '0;
                    end else if (grant_rd) begin
                        state        <= RD_CMD;
                        busy         <= 1'b1;
                        rf_pop       <= 1'b1;
                        mc_cmd_valid <= 1'b1;
                        mc_cmd_write <= 1'b0;
                        mc_cmd_addr  <= {rf_addr[31:4], 4'h0};
                        if (!wf_empty && (starve_cnt < SW'(WR_STARVE_MAX)))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                WR_CMD: begin
                    if (mc_cmd_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        mc_cmd_valid <= 1'b0;
                    end
                end
                RD_CMD: begin
                    if (mc_cmd_ready) begin
                        state        <= RD_WAIT;
                        mc_cmd_valid <= 1'b0;
                        timer        <= '0;
                    end
                end
                RD_WAIT: begin
                    if (mc_rdata_valid) begin
                        of_data <= mc_rdata;
                        state   <= RD_PUSH;
                    end else if (timer == TW'(RD_TIMEOUT)) begin
                        rd_timeout <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RD_PUSH: begin
                    if (!of_full) begin
                        of_push <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_fifo_scheduler.sv
// Scoreboard bench: FIFO and controller models feed the scheduler; expected commands and
// returned lines are queued at stimulus time and compared as the DUT produces them.
module tb_ddr3_fifo_scheduler;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] data;
    } cmd_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wf_empty = 1'b1;
    logic [31:0]  wf_addr = '0;
    logic [127:0] wf_data = '0;
    logic         wf_pop;
    logic         rf_empty = 1'b1;
    logic [31:0]  rf_addr = '0;
    logic         rf_pop;
    logic         of_full = 1'b0;
    logic         of_push;
    logic [127:0] of_data;
    logic         mc_cmd_valid;
    logic         mc_cmd_ready = 1'b0;
    logic         mc_cmd_write;
    logic [31:0]  mc_cmd_addr;
    logic [127:0] mc_wdata;
    logic         mc_rdata_valid = 1'b0;
    logic [127:0] mc_rdata = '0;
    logic         busy;
    logic         rd_timeout;

    ddr3_fifo_scheduler #(.WR_STARVE_MAX(8), .RD_TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n),
        .wf_empty(wf_empty), .wf_addr(wf_addr), .wf_data(wf_data), .wf_pop(wf_pop),
        .rf_empty(rf_empty), .rf_addr(rf_addr), .rf_pop(rf_pop),
        .of_full(of_full), .of_push(of_push), .of_data(of_data),
        .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_cmd_write(mc_cmd_write),
        .mc_cmd_addr(mc_cmd_addr), .mc_wdata(mc_wdata),
        .mc_rdata_valid(mc_rdata_valid), .mc_rdata(mc_rdata),
        .busy(busy), .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  wq_addr[$];
    logic [127:0] wq_data[$];
    logic [31:0]  rq_addr[$];
    logic [127:0] rdata_q[$];
    cmd_t         exp_cmd[$];
    logic [127:0] exp_out[$];

    int ready_delay = 0;
    int wait_ctr    = 0;
    int rd_lat      = 5;
    int rd_cd       = -1;
    bit no_resp     = 1'b0;
    int req_rv      = 0;
    int seen_rv     = 0;
    int wpops       = 0;
    int rpops       = 0;
    int opush       = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO, controller and read-out models, all evaluated away from the rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            wait_ctr       = 0;
            rd_cd          = -1;
            mc_cmd_ready   = 1'b0;
            mc_rdata_valid = 1'b0;
        end else begin
            if (wf_pop) begin
                wpops++;
                check("wf_pop_nonempty", 128'(wq_addr.size() != 0), 128'd1);
                if (wq_addr.size() != 0) begin
                    void'(wq_addr.pop_front());
                    void'(wq_data.pop_front());
                end
            end
            if (rf_pop) begin
                rpops++;
                check("rf_pop_nonempty", 128'(rq_addr.size() != 0), 128'd1);
                if (rq_addr.size() != 0) void'(rq_addr.pop_front());
            end

            mc_rdata_valid = 1'b0;
            if (rd_cd > 0) begin
                rd_cd--;
            end else if (rd_cd == 0) begin
                if (!no_resp && rdata_q.size() != 0) begin
                    mc_rdata_valid = 1'b1;
                    mc_rdata       = rdata_q.pop_front();
                end
                rd_cd = -1;
            end
            if (req_rv != seen_rv) begin
                seen_rv        = req_rv;
                mc_rdata_valid = 1'b1;
                mc_rdata       = {4{32'hBAADF00D}};
            end

            if (mc_cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", 128'd1, 128'd0);
                end else begin
                    check("cmd_write", 128'(mc_cmd_write), 128'(exp_cmd[0].wr));
                    check("cmd_addr", 128'(mc_cmd_addr), 128'(exp_cmd[0].addr));
                    if (exp_cmd[0].wr) check("cmd_wdata", mc_wdata, exp_cmd[0].data);
                end
                if (wait_ctr >= ready_delay) begin
                    mc_cmd_ready = 1'b1;
                    wait_ctr     = 0;
                    if (!mc_cmd_write) rd_cd = rd_lat;
                    if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                end else begin
                    mc_cmd_ready = 1'b0;
                    wait_ctr++;
                end
            end else begin
                mc_cmd_ready = 1'b0;
            end

            if (of_push) begin
                opush++;
                if (exp_out.size() == 0) check("push_unexpected", 128'd1, 128'd0);
                else check("of_data", of_data, exp_out.pop_front());
            end
        end
        wf_empty = (wq_addr.size() == 0);
        wf_addr  = (wq_addr.size() != 0) ? wq_addr[0] : '0;
        wf_data  = (wq_data.size() != 0) ? wq_data[0] : '0;
        rf_empty = (rq_addr.size() == 0);
        rf_addr  = (rq_addr.size() != 0) ? rq_addr[0] : '0;
    end

    task automatic exp_c(input logic wr, input logic [31:0] addr, input logic [127:0] data);
        cmd_t c;
        c.wr   = wr;
        c.addr = {addr[31:4], 4'h0};
        c.data = data;
        exp_cmd.push_back(c);
    endtask

    task automatic push_rd(input logic [31:0] addr, input logic [127:0] data);
        rq_addr.push_back(addr);
        rdata_q.push_back(data);
        exp_out.push_back(data);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_out.size() != 0 || busy ||
                wq_addr.size() != 0 || rq_addr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < budget), 128'd1);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mc_cmd_valid, mc_cmd_write, wf_pop, rf_pop, of_push, busy, rd_timeout,
                    mc_cmd_addr, mc_wdata, of_data}, '0);
    endtask

    initial begin
        int n;
        int base;

        #12;
        check_outputs_zero("reset_state");
        @(posedge clk); #1 reset_n = 1'b1;

        // Reset while a write command is being held by the controller.
        ready_delay = 100;
        wq_addr.push_back(32'h0000_2000);
        wq_data.push_back({4{32'h1111_2222}});
        exp_c(1'b1, 32'h0000_2000, {4{32'h1111_2222}});
        n = 0;
        while (!mc_cmd_valid && n < 50) begin @(negedge clk); n++; end
        check("rst_wr_started", 128'(mc_cmd_valid), 128'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        #1 check_outputs_zero("reset_mid_wr");
        exp_cmd.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ready_delay = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", 128'(busy), 128'd0);
            check("post_rst_pop", 128'({wf_pop, rf_pop}), 128'd0);
        end

        // Write only, held through three stalled cycles.
        @(posedge clk); #1;
        base = wpops;
        ready_delay = 3;
        wq_addr.push_back(32'h0000_1234);
        wq_data.push_back({16{8'hA5}});
        exp_c(1'b1, 32'h0000_1230, {16{8'hA5}});
        wait_drain("wr_drain", 100);
        check("wr_pop_once", 128'(wpops - base), 128'd1);
        ready_delay = 0;

        // Read with delayed read-out space.
        @(posedge clk); #1;
        base = opush;
        of_full = 1'b1;
        rd_lat = 5;
        exp_c(1'b0, 32'h0000_0040, '0);
        push_rd(32'h0000_0040, {4{32'hDEADBEEF}});
        n = 0;
        while (rdata_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("rd_data_returned", 128'(n < 100), 128'd1);
        repeat (6) @(negedge clk);
        check("rd_push_held", 128'(opush - base), 128'd0);
        check("rd_busy_held", 128'(busy), 128'd1);
        of_full = 1'b0;
        wait_drain("rd_drain", 100);
        check("rd_push_once", 128'(opush - base), 128'd1);

        // Same-line hazard: write issued before read.
        @(posedge clk); #1;
        rd_lat = 2;
        wq_addr.push_back(32'h0000_0100);
        wq_data.push_back({4{32'hCAFE_0100}});
        push_rd(32'h0000_0108, {4{32'h0108_0108}});
        exp_c(1'b1, 32'h0000_0100, {4{32'hCAFE_0100}});
        exp_c(1'b0, 32'h0000_0100, '0);
        wait_drain("hazard_drain", 200);

        // Starvation bound: 8 reads, then the pending write.
        @(posedge clk); #1;
        wq_addr.push_back(32'h0000_5000);
        wq_data.push_back({4{32'h5555_AAAA}});
        for (int i = 0; i < 12; i++) begin
            push_rd(32'h0000_1000 + 32'(i * 16), {4{32'h7000_0000 + 32'(i)}});
            if (i == 8) exp_c(1'b1, 32'h0000_5000, {4{32'h5555_AAAA}});
            exp_c(1'b0, 32'h0000_1000 + 32'(i * 16), '0);
        end
        wait_drain("starve_drain", 2000);

        // Read timeout, then a late rdata pulse must be ignored.
        @(posedge clk); #1;
        no_resp = 1'b1;
        rq_addr.push_back(32'h0000_0200);
        exp_c(1'b0, 32'h0000_0200, '0);
        n = 0;
        while (exp_cmd.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("to_accepted", 128'(n < 50), 128'd1);
        n = 0;
        while (!rd_timeout && n < 1100) begin @(negedge clk); n++; end
        check("to_seen", 128'(rd_timeout), 128'd1);
        check("to_cycles", 128'(n >= 1020 && n <= 1030), 128'd1);
        check("to_idle", 128'(busy), 128'd0);
        base = opush;
        req_rv++;
        repeat (5) @(negedge clk);
        check("to_late_ignored", 128'(opush - base), 128'd0);
        check("to_still_idle", 128'(busy), 128'd0);
        check("to_sticky", 128'(rd_timeout), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
